// File: rtl/regfile_pkg.sv
// Shared CPU datapath constants and types for the general-purpose register file.
package regfile_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_read_mux.sv
// NUM_REGS-to-1 combinational word selector used for each register-file read port.
module regfile_read_mux
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_REGS   = REG_COUNT
) (
    input  logic [DATA_WIDTH-1:0] words [NUM_REGS],
    input  logic [ADDR_WIDTH-1:0] sel,
    output logic [DATA_WIDTH-1:0] y
);

    // Address space exactly covers the array, so no range guard is needed.
    assign y = words[sel];

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// synchronous active-high clear. No write-to-read bypass; forwarding lives in the datapath.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_REGS   = REG_COUNT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RW,
    input  logic [ADDR_WIDTH-1:0] AA,
    input  logic [ADDR_WIDTH-1:0] BA,
    input  logic [ADDR_WIDTH-1:0] DA,
    input  logic [DATA_WIDTH-1:0] D_data,
    output logic [DATA_WIDTH-1:0] A_data,
    output logic [DATA_WIDTH-1:0] B_data
);

    logic [DATA_WIDTH-1:0] data [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_en;

    // One-hot write decode; R0 is an ordinary register.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign wr_en[gi] = RW && (DA == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) begin
                    data[i] <= D_data;
                end
            end
        end
    end

    regfile_read_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_mux_a (
        .words(data),
        .sel  (AA),
        .y    (A_data)
    );

    regfile_read_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_mux_b (
        .words(data),
        .sel  (BA),
        .y    (B_data)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed, table-driven checks of the register file: reset, writes, dual reads,
// write-disable, R0 writability, read-during-write and reset mid-operation.
module tb_regfile;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      RW;
    reg_addr_t AA, BA, DA;
    word_t     D_data;
    word_t     A_data, B_data;

    int total = 0;
    int bad   = 0;
    word_t exp_mem [REG_COUNT];

    regfile UUT (
        .clk   (clk),
        .reset (reset),
        .RW    (RW),
        .AA    (AA),
        .BA    (BA),
        .DA    (DA),
        .D_data(D_data),
        .A_data(A_data),
        .B_data(B_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic      rw;
        reg_addr_t aa;
        reg_addr_t ba;
        reg_addr_t da;
        word_t     d;
        word_t     exp_a;   // read value before the edge
        word_t     exp_b;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < REG_COUNT; i++) begin
            check($sformatf("%s data[%0d]", tag, i), UUT.data[i], exp_mem[i]);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  5'd0,  5'd5,  32'd1000,     32'd0,    32'd0};
        vecs[1] = '{1'b1, 5'd5,  5'd11, 5'd11, 32'd1500,     32'd1000, 32'd0};
        vecs[2] = '{1'b0, 5'd5,  5'd11, 5'd7,  32'hDEADBEEF, 32'd1000, 32'd1500};
        vecs[3] = '{1'b0, 5'd5,  5'd5,  5'd0,  32'd0,        32'd1000, 32'd1000};
        vecs[4] = '{1'b1, 5'd7,  5'd0,  5'd0,  32'd42,       32'd0,    32'd0};
        vecs[5] = '{1'b1, 5'd3,  5'd0,  5'd3,  32'd77,       32'd0,    32'd42};
        vecs[6] = '{1'b0, 5'd3,  5'd0,  5'd3,  32'd5,        32'd77,   32'd42};
        vecs[7] = '{1'b0, 5'd11, 5'd5,  5'd31, 32'd9,        32'd1500, 32'd1000};

        reset = 1'b1; RW = 1'b0; AA = '0; BA = '0; DA = '0; D_data = '0;
        tick(); tick();

        // Put arbitrary contents in, then clear with a 2-edge reset carrying a write.
        reset = 1'b0; RW = 1'b1;
        for (int i = 1; i < 4; i++) begin
            DA = reg_addr_t'(i); D_data = 32'h1234_0000 + i;
            tick();
        end
        reset = 1'b1; DA = 5'd4; D_data = 32'd55;
        tick(); tick();
        for (int i = 0; i < REG_COUNT; i++) exp_mem[i] = '0;
        check_all("reset");
        RW = 1'b0; AA = 5'd0; BA = 5'd31;
        #1;
        check("reset A_data", A_data, 32'd0);
        check("reset B_data", B_data, 32'd0);
        $display("txn reset: cleared, A=0x%08h B=0x%08h", A_data, B_data);

        // Table vectors: reads checked before the edge, then the edge commits the write.
        reset = 1'b0;
        for (int v = 0; v < 8; v++) begin
            RW = vecs[v].rw; AA = vecs[v].aa; BA = vecs[v].ba;
            DA = vecs[v].da; D_data = vecs[v].d;
            #1;
            check($sformatf("vec%0d A_data", v), A_data, vecs[v].exp_a);
            check($sformatf("vec%0d B_data", v), B_data, vecs[v].exp_b);
            $display("txn vec%0d: rw=%0d aa=%0d ba=%0d da=%0d d=0x%08h A=0x%08h B=0x%08h",
                     v, RW, AA, BA, DA, D_data, A_data, B_data);
            if (vecs[v].rw) exp_mem[vecs[v].da] = vecs[v].d;
            tick();
        end
        RW = 1'b0;
        check_all("table");

        // Read-during-write: old value until the edge, new value right after it.
        RW = 1'b1; AA = 5'd3; BA = 5'd3; DA = 5'd3; D_data = 32'hCAFE_0003;
        #1;
        check("rdw pre A_data", A_data, 32'd77);
        tick();
        RW = 1'b0;
        check("rdw post A_data", A_data, 32'hCAFE_0003);
        check("rdw post B_data", B_data, 32'hCAFE_0003);
        exp_mem[3] = 32'hCAFE_0003;
        $display("txn rdw: A=0x%08h B=0x%08h", A_data, B_data);

        // Walk every address through write and both read ports.
        RW = 1'b1;
        for (int i = 0; i < REG_COUNT; i++) begin
            DA = reg_addr_t'(i); D_data = {8'(i), 8'(~i), 8'(i * 3), 8'hA5};
            exp_mem[i] = D_data;
            tick();
        end
        RW = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            AA = reg_addr_t'(i); BA = reg_addr_t'(REG_COUNT - 1 - i);
            #1;
            check($sformatf("walk A[%0d]", i), A_data, exp_mem[i]);
            check($sformatf("walk B[%0d]", REG_COUNT - 1 - i), B_data, exp_mem[REG_COUNT - 1 - i]);
        end
        $display("txn walk: 32 registers written and read back");

        // Reset mid-operation with a pending write to R5.
        DA = 5'd5; D_data = 32'd1000; RW = 1'b1; tick();
        DA = 5'd11; D_data = 32'd1500; tick();
        reset = 1'b1; DA = 5'd5; D_data = 32'd9;
        tick();
        reset = 1'b0; RW = 1'b0; AA = 5'd5; BA = 5'd11;
        for (int i = 0; i < REG_COUNT; i++) exp_mem[i] = '0;
        check_all("midreset");
        #1;
        check("midreset A_data", A_data, 32'd0);
        check("midreset B_data", B_data, 32'd0);
        $display("txn midreset: A=0x%08h B=0x%08h", A_data, B_data);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file for the RISC CPU datapath: 32 registers × 32 bits.
- Two independent combinational read ports, A and B, feed the ALU and bus muxes.
- One synchronous write port, D, takes data from the writeback path.
- Synchronous reset clears every register.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, width of the AA, BA and DA address ports.
- NUM_REGS, 32, number of registers. Must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock. All state changes on the rising edge.
- reset  input  1  synchronous, active-high reset. Clears all registers.
- RW  input  1  register write enable. Active high.
- AA  input  ADDR_WIDTH  read address for port A.
- BA  input  ADDR_WIDTH  read address for port B.
- DA  input  ADDR_WIDTH  destination (write) address.
- D_data  input  DATA_WIDTH  write data.
- A_data  output  DATA_WIDTH  contents of register AA.
- B_data  output  DATA_WIDTH  contents of register BA.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, as already decided.
- Storage:
  - Array of NUM_REGS words, each DATA_WIDTH bits.
  - The array is named `data` so that benches can dump it hierarchically (UUT.data[i]).
- Reset:
  - On a rising edge with reset=1, all NUM_REGS entries become 0.
  - Reset has priority over a simultaneous write; a write presented during reset is discarded.
  - Reset asserted mid-operation clears everything at the next edge. No partial state survives.
- Write:
  - On a rising edge with reset=0 and RW=1, data[DA] <= D_data.
  - Exactly one register changes per cycle.
  - With RW=0, no register changes.
- R0 is an ordinary writable register; it is not hardwired to zero.
- Read:
  - A_data = data[AA] and B_data = data[BA], both purely combinational. Zero clock latency from address change.
  - AA == BA is legal: both outputs show the same value.
- Read-during-write:
  - When AA or BA equals DA while RW=1, the output shows the old value until the clock edge.
  - After the edge it shows the new value, through the combinational path.
  - There is no internal bypass; the datapath forwards if it needs to.
- Outputs after reset: A_data = B_data = 0 for any address.
- Before the first reset, contents are undefined (X in simulation). Benches must reset first.
- Out-of-range addresses cannot occur, since NUM_REGS = 2**ADDR_WIDTH.
- No pipeline or handshake. The write-back to read-visible latency is 1 clock edge.

Decomposition:
- A shared CPU package holds:
  - REG_DATA_W = 32
  - REG_ADDR_W = 5
  - REG_COUNT = 32
  - a typedef reg_addr_t (5 bits)
  - a typedef word_t (32 bits)
- Optional sub-module regfile_read_mux: a parameterised NUM_REGS-to-1 combinational mux, instantiated twice for ports A and B.
- The write decode and storage stay in regfile.

Test Plan:
- Reset clears all: arbitrary contents, hold reset=1 for 2 edges. Expect data[0..31] all 0, and A_data = B_data = 0 for AA=0, BA=31.
- Single writes:
  - reset=0, RW=1, DA=5, D_data=1000; one edge. Expect data[5]=1000, all others 0.
  - Then DA=11, D_data=1500. Expect data[11]=1500 and data[5] still 1000.
- Dual read: RW=0, AA=5, BA=11. Expect A_data=1000 and B_data=1500 combinationally, before any edge. AA=BA=5 gives 1000 on both.
- Write disable and R0:
  - RW=0, DA=7, D_data=0xDEADBEEF. Expect data[7] to remain 0.
  - RW=1, DA=0, D_data=42. Expect data[0]=42.
- Read-during-write: AA=DA=3, RW=1, D_data=77. Expect A_data=0 before the edge and 77 after it.
- Reset mid-operation: with R5=1000 and R11=1500, assert reset=1 with RW=1, DA=5, D_data=9. After the edge expect all registers 0, including R5.
